parity_scan_ctrl: RTL and testbench
===================================

Name: parity_scan_ctrl

Overview:
Sequencer that evaluates a WIDTH-bit word three bits at a time through one shared, purely combinational 3-input even-parity cell. The cell's output F is 1 when 0 or 2 of its inputs are high. The block latches a word on START and drives the cell with one 3-bit group per cycle, LSB group first. It collects the per-group results into a mask and a count, then reports completion with a one-cycle DONE pulse. It sits between a host register interface and a single parity-cell instance.

Parameters:
WIDTH, 12, input word width; must be a multiple of 3 and at least 3.
NGRP, WIDTH/3, number of 3-bit groups (derived; do not override).
CNT_W, 3, COUNT width; must be at least clog2(NGRP+1).

Ports:
CLK  in  1  rising-edge clock.
RST  in  1  synchronous, active-high reset.
START  in  1  request to begin a scan; accepted only in IDLE or DONE.
DATA  in  WIDTH  word to scan; sampled on the accepted START edge only.
CELL_A  out  1  to cell input A: bit 3*idx+2 of the latched word.
CELL_B  out  1  to cell input B: bit 3*idx+1 of the latched word.
CELL_C  out  1  to cell input C: bit 3*idx of the latched word.
CELL_F  in  1  cell output; combinational function of CELL_A/B/C within the same cycle.
BUSY  out  1  high while in RUN.
DONE  out  1  one-cycle pulse, high while in DONE.
MASK  out  NGRP  bit i = CELL_F result for group i.
COUNT  out  CNT_W  number of groups with F=1.
ALL_EVEN  out  1  high when MASK is all ones.

Behaviour:
- Single clock domain (CLK). Synchronous active-high reset RST. RST has priority over all other inputs.
- Reset values: state=IDLE, idx=0, latched word=0, BUSY=0, DONE=0, MASK=0, COUNT=0, ALL_EVEN=0, CELL_A/B/C=0.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - START=1 -> latch DATA, idx<=0, MASK<=0, COUNT<=0, go to RUN.
  - Otherwise stay; results hold their last values.
- RUN:
  - CELL_A/B/C are combinational from the latched word and idx.
  - Each cycle, on the clock edge: MASK[idx]<=CELL_F and COUNT<=COUNT+CELL_F.
  - If idx==NGRP-1 -> go to DONE; otherwise idx<=idx+1.
  - START is ignored.
- DONE (exactly one cycle):
  - DONE=1. MASK, COUNT and ALL_EVEN are final and stay held until the next accepted START.
  - START=1 here -> treated as in IDLE: latch, clear, go to RUN. This allows back-to-back scans.
  - Otherwise -> IDLE.
- CELL_A/B/C are 0 in IDLE and DONE.
- ALL_EVEN is registered and updates on the transition into DONE: ALL_EVEN = (final MASK is all ones).
- Latency: START sampled at edge t gives RUN from t through t+NGRP-1, with the DONE pulse in the cycle following edge t+NGRP. Total scan time is NGRP+1 cycles.
- COUNT never wraps when CNT_W >= clog2(NGRP+1).
- RST asserted mid-RUN: abort on that edge and return to the reset values. No DONE pulse is produced.
- START held high continuously: scans repeat every NGRP+1 cycles, re-latching DATA at each DONE.
- DATA changing during RUN has no effect on the scan in progress.

Test Plan:
1. RST then START with DATA=12'b000_011_110_101 (groups g3..g0) -> all groups have F=1. DONE pulses 5 cycles after START. MASK=4'b1111, COUNT=4, ALL_EVEN=1.
2. START with DATA=12'hFFF -> every group is 111, so F=0. MASK=0000, COUNT=0, ALL_EVEN=0.
3. START with DATA=12'b001_000_111_011 -> MASK=4'b0101, COUNT=2, ALL_EVEN=0. Check that CELL_A/B/C show 0/1/1, 1/1/1, 0/0/0, 0/0/1 on the four RUN cycles.
4. Pulse START again during RUN with different DATA -> ignored. Results match the first word, and BUSY stays high for exactly 4 cycles.
5. Assert RST on the 2nd RUN cycle -> next cycle is IDLE with all outputs 0 and no DONE pulse. A subsequent scan completes correctly.
6. Hold START=1 with DATA=12'hFFF, then change DATA to 12'h000 -> DONE pulses every 5 cycles. The second result is MASK=1111, COUNT=4, ALL_EVEN=1.

Source files
------------

// File: rtl/parity_scan_ctrl.sv
// parity_scan_ctrl
//
// Purpose:
//   Walks a latched WIDTH-bit word through one external 3-input even-parity
//   cell, one 3-bit group per cycle, starting with the least significant
//   group. Each group's cell result is stored in MASK, and the number of
//   even groups is accumulated in COUNT. When the last group is done, the
//   block raises a one-cycle DONE pulse.
//
// Ports:
//   CLK       rising-edge clock
//   RST       synchronous active-high reset
//   START     scan request, accepted only in IDLE or DONE
//   DATA      word to scan, sampled on the accepted START edge
//   CELL_A/B/C  current group bits {3*idx+2, 3*idx+1, 3*idx} to the cell
//   CELL_F    combinational cell result for the current group
//   BUSY      high while the scan is running
//   DONE      one-cycle completion pulse
//   MASK      per-group cell results (bit i = group i)
//   COUNT     number of groups whose cell result was 1
//   ALL_EVEN  high when every group in the last finished scan was even

module parity_scan_ctrl #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 3,
  localparam int NGRP = WIDTH / 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA,
  output logic             CELL_A,
  output logic             CELL_B,
  output logic             CELL_C,
  input  logic             CELL_F,
  output logic             BUSY,
  output logic             DONE,
  output logic [NGRP-1:0]  MASK,
  output logic [CNT_W-1:0] COUNT,
  output logic             ALL_EVEN
);

  localparam int IDX_W = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_word;
  logic [NGRP-1:0]  r_mask;
  logic [CNT_W-1:0] r_count;
  logic             r_allEven;
  logic [2:0]       w_group;
  logic [NGRP-1:0]  w_maskNext;
  logic             w_lastGrp;
  logic             w_accept;

  // START is only honoured once the previous scan has finished.
  assign w_accept  = START && (r_state != ST_RUN);
  assign w_lastGrp = (r_idx == IDX_W'(NGRP - 1));
  assign w_group   = r_word[3*r_idx +: 3];

  // The mask with the current group's result merged in. This value feeds
  // both the mask register and the ALL_EVEN decision on the final group.
  always_comb begin
    w_maskNext        = r_mask;
    w_maskNext[r_idx] = CELL_F;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. DONE is a pass-through state that lasts one cycle,
  // unless START arrives again and begins a back-to-back scan.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (START) w_nextState = ST_RUN;
      ST_RUN:  if (w_lastGrp) w_nextState = ST_DONE;
      ST_DONE: w_nextState = START ? ST_RUN : ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Datapath: latch the word on an accepted START, then collect one
  // cell result per RUN cycle. Results hold outside RUN until the next START.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx     <= '0;
      r_word    <= '0;
      r_mask    <= '0;
      r_count   <= '0;
      r_allEven <= 1'b0;
    end else if (w_accept) begin
      r_word    <= DATA;
      r_idx     <= '0;
      r_mask    <= '0;
      r_count   <= '0;
      r_allEven <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_mask  <= w_maskNext;
      r_count <= r_count + CNT_W'(CELL_F);
      if (w_lastGrp) begin
        r_allEven <= &w_maskNext;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Output logic. The cell is driven only during RUN so that it sees a
  // quiet zero input the rest of the time.
  always_comb begin
    BUSY   = (r_state == ST_RUN);
    DONE   = (r_state == ST_DONE);
    CELL_A = 1'b0;
    CELL_B = 1'b0;
    CELL_C = 1'b0;
    if (r_state == ST_RUN) begin
      CELL_A = w_group[2];
      CELL_B = w_group[1];
      CELL_C = w_group[0];
    end
  end

  assign MASK     = r_mask;
  assign COUNT    = r_count;
  assign ALL_EVEN = r_allEven;

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// tb_parity_scan_ctrl
//
// Purpose:
//   Self-checking bench for parity_scan_ctrl. It runs directed scans,
//   including mid-run START, mid-run reset, and held START, followed by
//   random words. Results are compared with a per-group parity model.
//
// Ports: none (top-level bench).

module tb_parity_scan_ctrl;

  localparam int WIDTH = 12;
  localparam int NGRP  = WIDTH / 3;
  localparam int CNT_W = 3;

  logic             CLK;
  logic             RST;
  logic             START;
  logic [WIDTH-1:0] DATA;
  logic             CELL_A;
  logic             CELL_B;
  logic             CELL_C;
  logic             CELL_F;
  logic             BUSY;
  logic             DONE;
  logic [NGRP-1:0]  MASK;
  logic [CNT_W-1:0] COUNT;
  logic             ALL_EVEN;

  int checkCount = 0;
  int passCount  = 0;

  parity_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DATA(DATA),
    .CELL_A(CELL_A), .CELL_B(CELL_B), .CELL_C(CELL_C), .CELL_F(CELL_F),
    .BUSY(BUSY), .DONE(DONE), .MASK(MASK), .COUNT(COUNT), .ALL_EVEN(ALL_EVEN)
  );

  // External even-parity cell: 1 when zero or two inputs are high.
  assign CELL_F = ($countones({CELL_A, CELL_B, CELL_C}) % 2) == 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: each group is even when it has an even number of ones.
  function automatic logic [NGRP-1:0] refMask(input logic [WIDTH-1:0] w);
    logic [NGRP-1:0] m;
    for (int g = 0; g < NGRP; g++) begin
      m[g] = ($countones(w[3*g +: 3]) % 2) == 0;
    end
    return m;
  endfunction

  // Advance one cycle and settle just after the active edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // After the scan returns to IDLE, results must hold and the cell inputs must be quiet.
  task automatic checkIdleHold(input logic [WIDTH-1:0] word);
    logic [NGRP-1:0] m;
    m = refMask(word);
    tick();
    checkOutput("idle_done", 32'(DONE), 32'd0);
    checkOutput("idle_busy", 32'(BUSY), 32'd0);
    checkOutput("idle_cells", 32'({CELL_A, CELL_B, CELL_C}), 32'd0);
    checkOutput("idle_mask", 32'(MASK), 32'(m));
    checkOutput("idle_count", 32'(COUNT), $countones(m));
  endtask

  // Run one scan of 'word'. START is sampled on the first edge. The task then
  // follows the NGRP RUN cycles and checks the DONE cycle. It returns while
  // still in the DONE cycle, so the caller can chain a back-to-back scan.
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input bit injectStart,
                               input bit abortRun, input bit holdStart);
    logic [NGRP-1:0] m;
    int busyCycles;
    m = refMask(word);
    busyCycles = 0;
    START = 1'b1;
    DATA  = word;
    tick();
    if (!holdStart) begin
      START = 1'b0;
      DATA  = WIDTH'($urandom);
    end
    for (int k = 0; k < NGRP; k++) begin
      if (BUSY) busyCycles++;
      checkOutput("run_busy", 32'(BUSY), 32'd1);
      checkOutput("run_done", 32'(DONE), 32'd0);
      checkOutput("run_cells", 32'({CELL_A, CELL_B, CELL_C}), 32'(word[3*k +: 3]));
      if (abortRun && k == 1) begin
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("abort_busy", 32'(BUSY), 32'd0);
        checkOutput("abort_done", 32'(DONE), 32'd0);
        checkOutput("abort_mask", 32'(MASK), 32'd0);
        checkOutput("abort_count", 32'(COUNT), 32'd0);
        checkOutput("abort_alleven", 32'(ALL_EVEN), 32'd0);
        checkOutput("abort_cells", 32'({CELL_A, CELL_B, CELL_C}), 32'd0);
        for (int j = 0; j < NGRP + 2; j++) begin
          tick();
          checkOutput("abort_nodone", 32'(DONE), 32'd0);
        end
        return;
      end
      if (injectStart && k == 1) begin
        START = 1'b1;
        DATA  = ~word;
      end else if (injectStart && k == 2) begin
        START = 1'b0;
      end
      tick();
    end
    checkOutput("done_pulse", 32'(DONE), 32'd1);
    checkOutput("done_busy", 32'(BUSY), 32'd0);
    checkOutput("done_cells", 32'({CELL_A, CELL_B, CELL_C}), 32'd0);
    checkOutput("done_mask", 32'(MASK), 32'(m));
    checkOutput("done_count", 32'(COUNT), $countones(m));
    checkOutput("done_alleven", 32'(ALL_EVEN), 32'(&m));
    checkOutput("busy_cycles", busyCycles, NGRP);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    RST   = 1'b1;
    START = 1'b0;
    DATA  = '0;
    tick();
    tick();
    RST = 1'b0;
    checkOutput("reset_busy", 32'(BUSY), 32'd0);
    checkOutput("reset_done", 32'(DONE), 32'd0);
    checkOutput("reset_mask", 32'(MASK), 32'd0);
    checkOutput("reset_count", 32'(COUNT), 32'd0);
    checkOutput("reset_alleven", 32'(ALL_EVEN), 32'd0);
    checkOutput("reset_cells", 32'({CELL_A, CELL_B, CELL_C}), 32'd0);

    $display("[TB] all-even word");
    applyStimulus(12'b000_011_110_101, 1'b0, 1'b0, 1'b0);
    checkIdleHold(12'b000_011_110_101);

    $display("[TB] all-odd word");
    applyStimulus(12'hFFF, 1'b0, 1'b0, 1'b0);
    checkIdleHold(12'hFFF);

    $display("[TB] mixed word");
    applyStimulus(12'b001_000_111_011, 1'b0, 1'b0, 1'b0);
    checkIdleHold(12'b001_000_111_011);

    $display("[TB] START during RUN is ignored");
    applyStimulus(12'b101_110_001_010, 1'b1, 1'b0, 1'b0);
    checkIdleHold(12'b101_110_001_010);

    $display("[TB] reset mid-run, then a clean scan");
    applyStimulus(12'b011_011_011_011, 1'b0, 1'b1, 1'b0);
    applyStimulus(12'b100_010_001_111, 1'b0, 1'b0, 1'b0);
    checkIdleHold(12'b100_010_001_111);

    $display("[TB] START held high, back-to-back scans");
    applyStimulus(12'hFFF, 1'b0, 1'b0, 1'b1);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0);
    checkIdleHold(12'h000);

    $display("[TB] random words");
    for (int n = 0; n < 20; n++) begin
      w = WIDTH'($urandom);
      applyStimulus(w, 1'b0, 1'b0, 1'b0);
      checkIdleHold(w);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
